lvt_write_scheduler: RTL
========================

Name: lvt_write_scheduler

Overview:
- Arbitrates write requests from NUM_PORTS accelerator/processor ports onto the single write port of a shared cache data bank.
- On each accepted write, also updates the live value table (LVT) entry for that address with the winning port ID, so read-side word muxes select the most recent writer.
- Supports a round-robin fair mode and a locked burst mode bounded by MAX_BURST, plus a stall input from the cache controller.

Parameters:
- NUM_PORTS, 4, number of requesting ports; 2..8.
- ADDR_WIDTH, 12, bank/LVT word address width.
- DATA_WIDTH, 32, write data width (one word).
- LVT_WIDTH, 2, port-ID width written into the LVT; must be >= ceil(log2(NUM_PORTS)).
- MAX_BURST, 8, maximum beats a locked port may hold the bank; 1..255.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- wr_req  in  NUM_PORTS  per-port write request (valid).
- wr_lock  in  NUM_PORTS  per-port request to keep the grant after this beat.
- wr_addr  in  NUM_PORTS*ADDR_WIDTH  per-port address; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- wr_data  in  NUM_PORTS*DATA_WIDTH  per-port data, packed the same way.
- bank_stall  in  1  cache busy (e.g. miss fill); blocks all grants.
- wr_ack  out  NUM_PORTS  combinational one-hot grant; a beat transfers on an edge where wr_req[i] and wr_ack[i] are both high.
- bank_we  out  1  registered bank write enable.
- bank_addr  out  ADDR_WIDTH  registered bank write address.
- bank_data  out  DATA_WIDTH  registered bank write data.
- lvt_we  out  1  registered LVT write enable; always equal to bank_we.
- lvt_addr  out  ADDR_WIDTH  registered LVT address; equal to bank_addr.
- lvt_data  out  LVT_WIDTH  registered winning port ID.
- owner  out  LVT_WIDTH  registered current lock owner; valid when locked=1.
- locked  out  1  registered; high while in the LOCKED state.

Behaviour:
- Reset (reset_n=0 at an edge):
  - state=IDLE, rr_ptr=0, beat_cnt=0.
  - bank_we=lvt_we=0; bank_addr, bank_data, lvt_addr, lvt_data, owner all 0; locked=0.
  - wr_ack=0 whenever reset_n=0.
  - Reset mid-burst aborts the burst; no write is issued for the beat on the reset edge.
- wr_ack (combinational):
  - All zero if bank_stall=1.
  - IDLE: one-hot on the first port with wr_req high, scanning rr_ptr, rr_ptr+1, ... modulo NUM_PORTS.
  - LOCKED: wr_ack[owner]=wr_req[owner]; all other ports 0.
- Write issue:
  - On an edge with a transfer from port i: bank_we=lvt_we=1 next cycle, bank_addr=lvt_addr=wr_addr[i], bank_data=wr_data[i], lvt_data=i.
  - Latency is exactly 1 cycle from transfer edge to registered write.
  - With no transfer, bank_we=lvt_we=0; address and data hold their previous values.
  - Throughput is 1 beat per cycle with no bubbles between ports.
- FSM, IDLE:
  - Transfer from i with wr_lock[i]=0 and MAX_BURST>1 not relevant: rr_ptr=(i+1) mod NUM_PORTS, stay IDLE.
  - Transfer from i with wr_lock[i]=1 and MAX_BURST>1: go to LOCKED, owner=i, beat_cnt=1; rr_ptr is unchanged.
  - With MAX_BURST=1, wr_lock is ignored and the IDLE-without-lock rule applies.
- FSM, LOCKED:
  - Each transfer increments beat_cnt.
  - Release when the transfer has wr_lock[owner]=0, or when beat_cnt+1 == MAX_BURST.
  - On release: go to IDLE, rr_ptr=(owner+1) mod NUM_PORTS, beat_cnt=0.
  - Owner wr_req=0: no grant, no write, stay LOCKED; beat_cnt unchanged. Bubbles do not count toward MAX_BURST.
- bank_stall=1: no transfer; FSM, rr_ptr, beat_cnt and owner all hold; bank_we=0 next cycle.
- Two ports writing the same address on consecutive beats: both writes are issued in order. The LVT holds the later port's ID.
- Requester rule: wr_addr, wr_data and wr_lock must be stable while wr_req is high and wr_ack is low. The scheduler does not check this.

Test Plan:
- Reset, then wr_req=4'b0000 -> wr_ack=0, bank_we=0, locked=0 for 5 cycles.
- Ports 0 and 2 request continuously; addr0=0x010, data0=0xAAAA0000, addr2=0x020, data2=0xCCCC0000 -> grants alternate 0,2,0,2; bank_we=1 every cycle from cycle 2; lvt_data alternates 0,2 with matching addr/data.
- Port 1 holds wr_lock=1 for 10 beats while port 3 requests, MAX_BURST=8 -> 8 consecutive port-1 writes, locked=1 and owner=1 throughout; then forced release; next grant goes to port 3.
- Locked port 1 drops wr_req for 2 cycles mid-burst -> no writes and no grant to port 3 during the gap; the burst resumes and beat_cnt is unaffected.
- bank_stall=1 for 3 cycles with all ports requesting -> wr_ack=0 and bank_we=0 during the stall; after the stall the round-robin order continues from the pre-stall rr_ptr.
- reset_n=0 during cycle 3 of a locked burst -> next cycle state=IDLE, locked=0, bank_we=0; the first grant after reset goes to the lowest requesting port at or after port 0.

Source files
------------

// File: rtl/lvt_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lvt_write_scheduler
// Purpose  : Arbitrates NUM_PORTS write requesters onto the single write port
//            of a shared cache data bank. It mirrors every accepted write
//            into the live value table with the winning port ID. Arbitration
//            is round-robin, with an optional locked burst of up to MAX_BURST
//            beats. bank_stall blocks every grant.
// Revision : 1.0 - initial release
// ============================================================================
module lvt_write_scheduler #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int LVT_WIDTH  = 2,
  parameter int MAX_BURST  = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_PORTS-1:0]             wr_req,
  input  logic [NUM_PORTS-1:0]             wr_lock,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  wr_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wr_data,
  input  logic                             bank_stall,
  output logic [NUM_PORTS-1:0]             wr_ack,
  output logic                             bank_we,
  output logic [ADDR_WIDTH-1:0]            bank_addr,
  output logic [DATA_WIDTH-1:0]            bank_data,
  output logic                             lvt_we,
  output logic [ADDR_WIDTH-1:0]            lvt_addr,
  output logic [LVT_WIDTH-1:0]             lvt_data,
  output logic [LVT_WIDTH-1:0]             owner,
  output logic                             locked
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Burst counter is 8 bits wide because MAX_BURST never exceeds 255.
  localparam logic [7:0]           C_MAX_BURST = 8'(MAX_BURST);
  // A single-beat burst limit makes locking meaningless, so wr_lock is ignored.
  localparam bit                   C_LOCK_EN   = (MAX_BURST > 1);
  localparam logic [LVT_WIDTH:0]   C_NUM_PORTS = (LVT_WIDTH+1)'(NUM_PORTS);

  // Port index + 1, wrapping at NUM_PORTS (which need not be a power of two).
  function automatic logic [LVT_WIDTH-1:0] wrap_inc(input logic [LVT_WIDTH-1:0] v);
    logic [LVT_WIDTH:0] s;
    s = {1'b0, v} + (LVT_WIDTH+1)'(1);
    if (s >= C_NUM_PORTS) s = '0;
    return s[LVT_WIDTH-1:0];
  endfunction

  state_t                r_state;
  state_t                w_state_next;
  logic [LVT_WIDTH-1:0]  r_rr_ptr;
  logic [LVT_WIDTH-1:0]  w_rr_ptr_next;
  logic [LVT_WIDTH-1:0]  r_owner;
  logic [LVT_WIDTH-1:0]  w_owner_next;
  logic [7:0]            r_beat_cnt;
  logic [7:0]            w_beat_cnt_next;

  logic [NUM_PORTS-1:0]  w_ack;
  logic                  w_xfer;
  logic                  w_sel_lock;
  logic [LVT_WIDTH-1:0]  w_sel_id;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;

  logic                  r_bank_we;
  logic [ADDR_WIDTH-1:0] r_bank_addr;
  logic [DATA_WIDTH-1:0] r_bank_data;
  logic [LVT_WIDTH-1:0]  r_lvt_data;

  // Grant: the owner only while locked, otherwise the first requester from rr_ptr upward.
  always_comb begin
    logic               found;
    logic [LVT_WIDTH:0] idx;
    w_ack = '0;
    found = 1'b0;
    idx   = '0;
    if (reset_n && !bank_stall) begin
      if (r_state == ST_LOCKED) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (r_owner == LVT_WIDTH'(i)) w_ack[i] = wr_req[i];
        end
      end else begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          idx = {1'b0, r_rr_ptr} + (LVT_WIDTH+1)'(k);
          if (idx >= C_NUM_PORTS) idx = idx - C_NUM_PORTS;
          for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && (idx == (LVT_WIDTH+1)'(i)) && wr_req[i]) begin
              w_ack[i] = 1'b1;
              found    = 1'b1;
            end
          end
        end
      end
    end
  end

  // Select the transferring port's address, data, lock flag and ID.
  always_comb begin
    w_xfer     = |w_ack;
    w_sel_lock = |(w_ack & wr_lock);
    w_sel_id   = '0;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_ack[i]) begin
        w_sel_id   = LVT_WIDTH'(i);
        w_sel_addr = wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_data = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state logic for lock entry/release, the round-robin pointer and the burst count.
  always_comb begin
    w_state_next    = r_state;
    w_rr_ptr_next   = r_rr_ptr;
    w_owner_next    = r_owner;
    w_beat_cnt_next = r_beat_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          if (C_LOCK_EN && w_sel_lock) begin
            // The pointer stays put; it advances past the owner on release.
            w_state_next    = ST_LOCKED;
            w_owner_next    = w_sel_id;
            w_beat_cnt_next = 8'd1;
          end else begin
            w_rr_ptr_next = wrap_inc(w_sel_id);
          end
        end
      end
      ST_LOCKED: begin
        // Bubbles (owner not requesting) leave the beat count untouched.
        if (w_xfer) begin
          if (!w_sel_lock || (r_beat_cnt + 8'd1 == C_MAX_BURST)) begin
            w_state_next    = ST_IDLE;
            w_rr_ptr_next   = wrap_inc(r_owner);
            w_beat_cnt_next = 8'd0;
          end else begin
            w_beat_cnt_next = r_beat_cnt + 8'd1;
          end
        end
      end
      default: begin
        w_state_next    = ST_IDLE;
        w_beat_cnt_next = 8'd0;
      end
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_next;
      r_rr_ptr   <= w_rr_ptr_next;
      r_owner    <= w_owner_next;
      r_beat_cnt <= w_beat_cnt_next;
    end
  end

  // Registered bank/LVT write; address, data and ID hold when nothing transfers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_bank_we   <= 1'b0;
      r_bank_addr <= '0;
      r_bank_data <= '0;
      r_lvt_data  <= '0;
    end else begin
      r_bank_we <= w_xfer;
      if (w_xfer) begin
        r_bank_addr <= w_sel_addr;
        r_bank_data <= w_sel_data;
        r_lvt_data  <= w_sel_id;
      end
    end
  end

  assign wr_ack    = w_ack;
  assign bank_we   = r_bank_we;
  assign bank_addr = r_bank_addr;
  assign bank_data = r_bank_data;
  assign lvt_we    = r_bank_we;
  assign lvt_addr  = r_bank_addr;
  assign lvt_data  = r_lvt_data;
  assign owner     = r_owner;
  assign locked    = (r_state == ST_LOCKED);

endmodule
`default_nettype wire
